// File: rtl/universal_register_pkg.sv
// Shared mode encoding for universal_register; controllers drive one mode code
// instead of separate load/shift/count enables.
package universal_register_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        HOLD = 3'd0,
        LOAD = 3'd1,
        SHL  = 3'd2,
        SHR  = 3'd3,
        ROL  = 3'd4,
        ROR  = 3'd5,
        INC  = 3'd6,
        DEC  = 3'd7
    } reg_mode_e;

endpackage

// File: rtl/universal_register.sv
// Multi-mode register (masked load, shift, rotate, inc/dec) with registered carry and
// combinational zero flag; one-cycle latency, no flow control (accepts every cycle).
module universal_register
    import universal_register_pkg::*;
#(
    parameter int unsigned     size      = 8,
    parameter logic [size-1:0] RESET_VAL = '0,
    parameter logic [size-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [MODE_W-1:0] mode,
    input  logic [size-1:0]   dataIn,
    input  logic [size-1:0]   loadMask,
    input  logic              serialIn,
    output logic [size-1:0]   dataOut,
    output logic              carry,
    output logic              zero
);

    localparam logic [size:0] ONE = {{size{1'b0}}, 1'b1};

    logic [size-1:0] data_q, data_d;
    logic            carry_q, carry_d;
    logic [size:0]   arith;

    // The size+1 bit result carries INC overflow and DEC borrow in its top bit.
    always_comb begin
        data_d  = data_q;
        carry_d = carry_q;
        arith   = {1'b0, data_q};
        case (mode)
            LOAD: begin
                data_d  = (dataIn & loadMask) | (data_q & ~loadMask);
                carry_d = 1'b0;
            end
            SHL: begin
                data_d  = {data_q[size-2:0], serialIn};
                carry_d = data_q[size-1];
            end
            SHR: begin
                data_d  = {serialIn, data_q[size-1:1]};
                carry_d = data_q[0];
            end
            ROL: begin
                data_d  = {data_q[size-2:0], data_q[size-1]};
                carry_d = data_q[size-1];
            end
            ROR: begin
                data_d  = {data_q[0], data_q[size-1:1]};
                carry_d = data_q[0];
            end
            INC: begin
                arith   = {1'b0, data_q} + ONE;
                data_d  = arith[size-1:0];
                carry_d = arith[size];
            end
            DEC: begin
                arith   = {1'b0, data_q} - ONE;
                data_d  = arith[size-1:0];
                carry_d = arith[size];
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= RESET_VAL;
            carry_q <= 1'b0;
        end else if (clear) begin
            data_q  <= CLEAR_VAL;
            carry_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            carry_q <= carry_d;
        end
    end

    assign dataOut = data_q;
    assign carry   = carry_q;
    assign zero    = (data_q == '0);

    a_reset_val: assert property (@(posedge clk) rst |=> (dataOut == RESET_VAL));

    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (!clear && mode == HOLD) |=> ($stable(dataOut) && $stable(carry)));

    a_zero_flag: assert property (@(posedge clk) disable iff (rst)
        zero == (dataOut == '0));

    a_inc_wrap: assert property (@(posedge clk) disable iff (rst)
        (!clear && mode == INC && dataOut == '1) |=> (dataOut == '0 && carry));

    a_mode_known: assert property (@(posedge clk)
        (!rst && !clear) |-> !$isunknown(mode));

endmodule

// File: tb/tb_universal_register.sv
// Bench for universal_register: directed plan plus random regression against an
// integer reference model, on two instances with different reset/clear values.
module tb_universal_register;
    import universal_register_pkg::*;

    logic       clk = 1'b0;
    logic       rst, clear, serialIn;
    logic [2:0] mode;
    logic [7:0] dataIn, loadMask;
    logic [7:0] dout_a, dout_b;
    logic       carry_a, carry_b, zero_a, zero_b;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state per instance: index 0 = defaults, 1 = RESET 0x11 / CLEAR 0x22.
    int ref_v[2];
    int ref_c[2];
    int rst_v[2] = '{0, 'h11};
    int clr_v[2] = '{0, 'h22};

    always #5 clk = ~clk;

    universal_register #(.size(8), .RESET_VAL(8'h00), .CLEAR_VAL(8'h00)) dut_a (
        .clk(clk), .rst(rst), .clear(clear), .mode(mode), .dataIn(dataIn),
        .loadMask(loadMask), .serialIn(serialIn),
        .dataOut(dout_a), .carry(carry_a), .zero(zero_a)
    );

    universal_register #(.size(8), .RESET_VAL(8'h11), .CLEAR_VAL(8'h22)) dut_b (
        .clk(clk), .rst(rst), .clear(clear), .mode(mode), .dataIn(dataIn),
        .loadMask(loadMask), .serialIn(serialIn),
        .dataOut(dout_b), .carry(carry_b), .zero(zero_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply inputs, take one edge, advance the model, then compare both instances.
    task automatic tick(input logic r, input logic c, input logic [2:0] m,
                        input logic [7:0] d, input logic [7:0] msk, input logic s);
        int v, cy, t;
        rst = r; clear = c; mode = m; dataIn = d; loadMask = msk; serialIn = s;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            v  = ref_v[i];
            cy = ref_c[i];
            if (r) begin
                v = rst_v[i]; cy = 0;
            end else if (c) begin
                v = clr_v[i]; cy = 0;
            end else begin
                case (m)
                    3'd1: begin v = (int'(d) & int'(msk)) | (v & (~int'(msk) & 255)); cy = 0; end
                    3'd2: begin cy = (v >> 7) & 1; v = ((v * 2) + int'(s)) % 256; end
                    3'd3: begin cy = v & 1; v = (v / 2) + 128 * int'(s); end
                    3'd4: begin cy = (v >> 7) & 1; v = ((v * 2) % 256) + cy; end
                    3'd5: begin cy = v & 1; v = (v / 2) + 128 * cy; end
                    3'd6: begin t = v + 1; cy = (t > 255) ? 1 : 0; v = t % 256; end
                    3'd7: begin cy = (v == 0) ? 1 : 0; v = (v + 255) % 256; end
                    default: ;
                endcase
            end
            ref_v[i] = v;
            ref_c[i] = cy;
        end
        #1;
        chk("data_a",  32'(dout_a),  32'(ref_v[0]));
        chk("carry_a", 32'(carry_a), 32'(ref_c[0]));
        chk("zero_a",  32'(zero_a),  (ref_v[0] == 0) ? 32'd1 : 32'd0);
        chk("data_b",  32'(dout_b),  32'(ref_v[1]));
        chk("carry_b", 32'(carry_b), 32'(ref_c[1]));
        chk("zero_b",  32'(zero_b),  (ref_v[1] == 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        logic [7:0] rmask;
        rst = 1'b1; clear = 1'b0; mode = HOLD; dataIn = '0; loadMask = '0; serialIn = 1'b0;
        ref_v = '{0, 0};
        ref_c = '{0, 0};

        // Reset and clear
        tick(1, 0, HOLD, 8'h00, 8'h00, 0);
        tick(1, 0, HOLD, 8'h00, 8'h00, 0);
        chk("rst_data", 32'(dout_a), 32'h00);
        chk("rst_zero", 32'(zero_a), 32'd1);
        chk("rst_data_b", 32'(dout_b), 32'h11);
        tick(0, 0, LOAD, 8'hA5, 8'hFF, 0);
        chk("load_a5", 32'(dout_a), 32'hA5);
        chk("load_a5_carry", 32'(carry_a), 32'd0);
        chk("load_a5_zero", 32'(zero_a), 32'd0);
        tick(0, 1, INC, 8'h00, 8'h00, 0);
        chk("clear_data", 32'(dout_a), 32'h00);
        chk("clear_zero", 32'(zero_a), 32'd1);
        chk("clear_data_b", 32'(dout_b), 32'h22);

        // Masked load
        tick(0, 0, LOAD, 8'hA5, 8'hFF, 0);
        tick(0, 0, LOAD, 8'h3C, 8'h0F, 0);
        chk("masked_load", 32'(dout_a), 32'hAC);

        // Shift / rotate sequence from 0x81
        tick(0, 0, LOAD, 8'h81, 8'hFF, 0);
        tick(0, 0, SHL, 8'h00, 8'h00, 0);
        chk("shl", 32'({carry_a, dout_a}), 32'h102);
        tick(0, 0, SHR, 8'h00, 8'h00, 1);
        chk("shr", 32'({carry_a, dout_a}), 32'h081);
        tick(0, 0, ROR, 8'h00, 8'h00, 0);
        chk("ror", 32'({carry_a, dout_a}), 32'h1C0);
        tick(0, 0, ROL, 8'h00, 8'h00, 1);
        chk("rol", 32'({carry_a, dout_a}), 32'h181);

        // Counter wrap in both directions
        tick(0, 0, LOAD, 8'hFE, 8'hFF, 0);
        tick(0, 0, INC, 8'h00, 8'h00, 0);
        chk("inc_ff", 32'({carry_a, dout_a}), 32'h0FF);
        tick(0, 0, INC, 8'h00, 8'h00, 0);
        chk("inc_wrap", 32'({carry_a, dout_a}), 32'h100);
        chk("inc_wrap_zero", 32'(zero_a), 32'd1);
        tick(0, 0, DEC, 8'h00, 8'h00, 0);
        chk("dec_borrow", 32'({carry_a, dout_a}), 32'h1FF);
        tick(0, 0, LOAD, 8'h12, 8'h00, 0);
        chk("load_mask0", 32'({carry_a, dout_a}), 32'h0FF);
        tick(0, 0, DEC, 8'h00, 8'h00, 0);
        chk("dec_fe", 32'({carry_a, dout_a}), 32'h0FE);

        // HOLD with toggling dataIn
        tick(0, 0, LOAD, 8'h55, 8'hFF, 0);
        for (int k = 0; k < 5; k++) begin
            tick(0, 0, HOLD, (k % 2 == 0) ? 8'hAA : 8'h00, 8'hFF, k[0]);
            chk("hold", 32'({carry_a, dout_a}), 32'h055);
        end

        // rst beats clear
        tick(1, 1, INC, 8'h00, 8'h00, 0);
        chk("prio_b", 32'(dout_b), 32'h11);
        chk("prio_a", 32'(dout_a), 32'h00);

        // Random regression
        for (int n = 0; n < 10000; n++) begin
            case ($urandom_range(3))
                0: rmask = 8'hFF;
                1: rmask = 8'h00;
                default: rmask = 8'($urandom);
            endcase
            tick(($urandom_range(99) < 2) ? 1'b1 : 1'b0,
                 ($urandom_range(99) < 4) ? 1'b1 : 1'b0,
                 3'($urandom_range(7)), 8'($urandom), rmask, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
